frame_sequencer: RTL and testbench

- Paced frame-playback controller for the LED panel animation path.
- Issues one load request per frame period to the flash loader, with the flash address of the current frame. Supports loop, ping-pong and one-shot playback, pause/resume, restart, runtime frame count, and loader back-pressure.
- Sits between the clock domain root and flash_loader (o_load_stb/o_load_addr drive its read strobe/address). Replaces the hard-wired 12-frame/100 ms counter in the top level.

---
 rtl/panel_pkg.sv | 24 ++
 rtl/frame_period_timer.sv | 37 +++
 rtl/frame_sequencer.sv | 162 ++++++++++++++++
 tb/tb_frame_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/panel_pkg.sv
// ============================================================================
// panel_pkg : shared encodings and defaults for the LED panel playback path
// Rev 1.0
// ============================================================================
`default_nettype none

package panel_pkg;

  localparam logic [1:0] MODE_LOOP     = 2'd0;
  localparam logic [1:0] MODE_PINGPONG = 2'd1;
  localparam logic [1:0] MODE_ONESHOT  = 2'd2;

  localparam logic [23:0] DEFAULT_BASE_ADDR   = 24'h80_0000;
  localparam int          DEFAULT_FRAME_SHIFT = 13;

  typedef enum logic [1:0] {
    S_PRIME = 2'd0,
    S_RUN   = 2'd1,
    S_DONE  = 2'd2
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/frame_period_timer.sv
// ============================================================================
// frame_period_timer : loadable down-counter that ticks on zero while enabled
// Rev 1.0
// ============================================================================
`default_nettype none

module frame_period_timer #(
  parameter int PERIOD_W = 23
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_load,
  input  logic                i_run,
  input  logic                i_enable,
  input  logic [PERIOD_W-1:0] i_period,
  output logic                o_tick
);

  logic [PERIOD_W-1:0] r_count;

  assign o_tick = i_run & i_enable & (r_count == '0);

  // A tick reloads the period on its own, so the caller only loads on prime/restart.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_period;
    end else if (i_run && i_enable) begin
      if (r_count == '0) r_count <= i_period;
      else               r_count <= r_count - PERIOD_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/frame_sequencer.sv
// ============================================================================
// frame_sequencer : paced frame playback, one flash load request per period
// Rev 1.0
// ============================================================================
`default_nettype none

module frame_sequencer
  import panel_pkg::*;
#(
  parameter int                FRAME_W     = 8,
  parameter int                PERIOD_W    = 23,
  parameter int                ADDR_W      = 24,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(DEFAULT_BASE_ADDR),
  parameter int                FRAME_SHIFT = DEFAULT_FRAME_SHIFT
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic [1:0]          i_mode,
  input  logic [FRAME_W-1:0]  i_frame_count,
  input  logic [PERIOD_W-1:0] i_period,
  input  logic                i_restart,
  input  logic                i_load_busy,
  output logic                o_load_stb,
  output logic [ADDR_W-1:0]   o_load_addr,
  output logic [FRAME_W-1:0]  o_frame_index,
  output logic                o_done,
  output logic                o_dropped
);

  seq_state_t         r_state, w_state_nxt;
  logic [FRAME_W-1:0] r_idx, w_idx_nxt;
  logic               r_fwd, w_fwd_nxt;
  logic               r_stb, w_stb_nxt;
  logic               r_done, w_done_nxt;
  logic               r_dropped, w_dropped_nxt;
  logic [ADDR_W-1:0]  r_addr;

  logic               w_tick, w_load, w_run;
  logic [FRAME_W-1:0] w_n, w_last;
  logic [FRAME_W-1:0] w_adv_idx;
  logic               w_adv_fwd, w_adv_end;

  assign w_run  = (r_state == S_RUN);
  assign w_n    = (i_frame_count == '0) ? FRAME_W'(1) : i_frame_count;
  assign w_last = w_n - FRAME_W'(1);

  frame_period_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_load   (w_load),
    .i_run    (w_run),
    .i_enable (i_enable),
    .i_period (i_period),
    .o_tick   (w_tick)
  );

  // Next frame per playback mode; an index beyond the live count snaps back to 0.
  always_comb begin
    w_adv_idx = r_idx + FRAME_W'(1);
    w_adv_fwd = 1'b1;
    w_adv_end = 1'b0;
    case (i_mode)
      MODE_PINGPONG: begin
        if (r_idx > w_last || w_last == '0) begin
          w_adv_idx = '0;
        end else if (r_fwd) begin
          if (r_idx == w_last) begin
            w_adv_idx = w_last - FRAME_W'(1);
            w_adv_fwd = 1'b0;
          end
        end else if (r_idx == '0) begin
          w_adv_idx = FRAME_W'(1);
        end else begin
          w_adv_idx = r_idx - FRAME_W'(1);
          w_adv_fwd = 1'b0;
        end
      end
      MODE_ONESHOT: begin
        if (r_idx >= w_last) begin
          w_adv_idx = r_idx;
          w_adv_end = 1'b1;
        end
      end
      default: begin
        if (r_idx >= w_last) w_adv_idx = '0;
      end
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_fwd_nxt     = r_fwd;
    w_stb_nxt     = 1'b0;
    w_done_nxt    = r_done;
    w_dropped_nxt = 1'b0;
    w_load        = 1'b0;
    if (i_restart) begin
      w_state_nxt = S_RUN;
      w_idx_nxt   = '0;
      w_fwd_nxt   = 1'b1;
      w_done_nxt  = 1'b0;
      w_stb_nxt   = 1'b1;
      w_load      = 1'b1;
    end else begin
      case (r_state)
        S_PRIME: begin
          w_state_nxt = S_RUN;
          w_stb_nxt   = 1'b1;
          w_load      = 1'b1;
        end
        S_RUN: begin
          if (w_tick) begin
            if (i_load_busy) begin
              w_dropped_nxt = 1'b1;
            end else if (w_adv_end) begin
              w_state_nxt = S_DONE;
              w_done_nxt  = 1'b1;
            end else begin
              w_idx_nxt = w_adv_idx;
              w_fwd_nxt = w_adv_fwd;
              w_stb_nxt = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_PRIME;
      r_idx     <= '0;
      r_fwd     <= 1'b1;
      r_stb     <= 1'b0;
      r_done    <= 1'b0;
      r_dropped <= 1'b0;
      r_addr    <= BASE_ADDR;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_fwd     <= w_fwd_nxt;
      r_stb     <= w_stb_nxt;
      r_done    <= w_done_nxt;
      r_dropped <= w_dropped_nxt;
      r_addr    <= BASE_ADDR + (ADDR_W'(w_idx_nxt) << FRAME_SHIFT);
    end
  end

  assign o_load_stb    = r_stb;
  assign o_load_addr   = r_addr;
  assign o_frame_index = r_idx;
  assign o_done        = r_done;
  assign o_dropped     = r_dropped;

endmodule

`default_nettype wire

// File: tb/tb_frame_sequencer.sv
// ============================================================================
// tb_frame_sequencer : directed self-checking bench for frame_sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_enable = 1'b1;
  logic [1:0]  i_mode = 2'd0;
  logic [7:0]  i_frame_count = 8'd3;
  logic [22:0] i_period = 23'd9;
  logic        i_restart = 1'b0;
  logic        i_load_busy = 1'b0;
  logic        o_load_stb;
  logic [23:0] o_load_addr;
  logic [7:0]  o_frame_index;
  logic        o_done;
  logic        o_dropped;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  frame_sequencer u_dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_enable      (i_enable),
    .i_mode        (i_mode),
    .i_frame_count (i_frame_count),
    .i_period      (i_period),
    .i_restart     (i_restart),
    .i_load_busy   (i_load_busy),
    .o_load_stb    (o_load_stb),
    .o_load_addr   (o_load_addr),
    .o_frame_index (o_frame_index),
    .o_done        (o_done),
    .o_dropped     (o_dropped)
  );

  // Counts falling edges until a strobe is seen, giving up after max_cyc.
  task automatic wait_stb(input int max_cyc, output int gap, output bit got);
    got = 1'b0;
    gap = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      gap++;
      if (o_load_stb) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_restart();
    i_restart = 1'b1;
    @(negedge clk);
    i_restart = 1'b0;
  endtask

  task automatic test_reset();
    int gap;
    bit got;
    logic [7:0]  exp_idx  [3] = '{8'd1, 8'd2, 8'd0};
    logic [23:0] exp_addr [3] = '{24'h80_2000, 24'h80_4000, 24'h80_0000};
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({o_load_stb, o_frame_index, o_load_addr, o_done, o_dropped} !== {1'b0, 8'd0, 24'h80_0000, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_values: got stb=%b idx=%0d addr=%h done=%b drop=%b, want 0/0/800000/0/0",
               o_load_stb, o_frame_index, o_load_addr, o_done, o_dropped);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_load_stb !== 1'b1 || o_frame_index !== 8'd0 || o_load_addr !== 24'h80_0000) begin
      n_errors++;
      $display("FAIL prime_strobe: got stb=%b idx=%0d addr=%h, want 1/0/800000",
               o_load_stb, o_frame_index, o_load_addr);
    end
    for (int k = 0; k < 3; k++) begin
      wait_stb(40, gap, got);
      n_checks++;
      if (!got || gap != 10 || o_frame_index !== exp_idx[k] || o_load_addr !== exp_addr[k]) begin
        n_errors++;
        $display("FAIL loop_step%0d: got strobe=%b gap=%0d idx=%0d addr=%h, want 1/10/%0d/%h",
                 k, got, gap, o_frame_index, o_load_addr, exp_idx[k], exp_addr[k]);
      end
    end
  endtask

  task automatic test_pingpong();
    int gap;
    bit got;
    logic [7:0] exp_idx [7] = '{8'd1, 8'd2, 8'd3, 8'd2, 8'd1, 8'd0, 8'd1};
    i_mode = 2'd1;
    i_frame_count = 8'd4;
    pulse_restart();
    n_checks++;
    if (o_load_stb !== 1'b1 || o_frame_index !== 8'd0) begin
      n_errors++;
      $display("FAIL pp_restart: got stb=%b idx=%0d, want 1/0", o_load_stb, o_frame_index);
    end
    for (int k = 0; k < 7; k++) begin
      wait_stb(40, gap, got);
      n_checks++;
      if (!got || gap != 10 || o_frame_index !== exp_idx[k]) begin
        n_errors++;
        $display("FAIL pp_step%0d: got strobe=%b gap=%0d idx=%0d, want 1/10/%0d",
                 k, got, gap, o_frame_index, exp_idx[k]);
      end
      if (k == 2) begin
        n_checks++;
        if (o_load_addr !== 24'h80_6000) begin
          n_errors++;
          $display("FAIL pp_addr3: got %h, want 806000", o_load_addr);
        end
      end
    end
    i_frame_count = 8'd1;
    pulse_restart();
    for (int k = 0; k < 3; k++) begin
      wait_stb(40, gap, got);
      n_checks++;
      if (!got || gap != 10 || o_frame_index !== 8'd0) begin
        n_errors++;
        $display("FAIL pp_n1_step%0d: got strobe=%b gap=%0d idx=%0d, want 1/10/0",
                 k, got, gap, o_frame_index);
      end
    end
  endtask

  task automatic test_oneshot();
    int gap;
    bit got;
    int stray;
    i_mode = 2'd2;
    i_frame_count = 8'd3;
    pulse_restart();
    for (int k = 1; k <= 2; k++) begin
      wait_stb(40, gap, got);
      n_checks++;
      if (!got || gap != 10 || o_frame_index !== 8'(k)) begin
        n_errors++;
        $display("FAIL os_step%0d: got strobe=%b gap=%0d idx=%0d, want 1/10/%0d",
                 k, got, gap, o_frame_index, k);
      end
    end
    stray = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_load_stb) stray++;
    end
    n_checks++;
    if (stray != 0 || o_done !== 1'b1 || o_frame_index !== 8'd2) begin
      n_errors++;
      $display("FAIL os_done: got strobes=%0d done=%b idx=%0d, want 0/1/2", stray, o_done, o_frame_index);
    end
    repeat (25) begin
      @(negedge clk);
      if (o_load_stb) stray++;
    end
    n_checks++;
    if (stray != 0 || o_done !== 1'b1) begin
      n_errors++;
      $display("FAIL os_hold: got strobes=%0d done=%b, want 0/1", stray, o_done);
    end
    pulse_restart();
    n_checks++;
    if (o_done !== 1'b0 || o_load_stb !== 1'b1 || o_frame_index !== 8'd0) begin
      n_errors++;
      $display("FAIL os_restart: got done=%b stb=%b idx=%0d, want 0/1/0", o_done, o_load_stb, o_frame_index);
    end
  endtask

  task automatic test_busy();
    int gap;
    bit got;
    int stray;
    int drop_at;
    i_mode = 2'd0;
    i_frame_count = 8'd3;
    pulse_restart();
    wait_stb(40, gap, got);
    i_load_busy = 1'b1;
    stray = 0;
    drop_at = -1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (o_load_stb) stray++;
      if (o_dropped && drop_at < 0) drop_at = c;
    end
    n_checks++;
    if (stray != 0 || drop_at != 10 || o_frame_index !== 8'd1 || o_dropped !== 1'b0) begin
      n_errors++;
      $display("FAIL busy_drop: got strobes=%0d drop_at=%0d idx=%0d drop_now=%b, want 0/10/1/0",
               stray, drop_at, o_frame_index, o_dropped);
    end
    i_load_busy = 1'b0;
    wait_stb(40, gap, got);
    n_checks++;
    if (!got || gap != 8 || o_frame_index !== 8'd2) begin
      n_errors++;
      $display("FAIL busy_resume: got strobe=%b gap=%0d idx=%0d, want 1/8/2", got, gap, o_frame_index);
    end
  endtask

  task automatic test_pause();
    int gap;
    bit got;
    int stray;
    i_mode = 2'd0;
    i_frame_count = 8'd3;
    pulse_restart();
    repeat (5) @(negedge clk);
    i_enable = 1'b0;
    stray = 0;
    repeat (50) begin
      @(negedge clk);
      if (o_load_stb) stray++;
    end
    n_checks++;
    if (stray != 0) begin
      n_errors++;
      $display("FAIL pause_hold: got %0d strobes, want 0", stray);
    end
    i_enable = 1'b1;
    wait_stb(40, gap, got);
    n_checks++;
    if (!got || gap != 5 || o_frame_index !== 8'd1) begin
      n_errors++;
      $display("FAIL pause_resume: got strobe=%b gap=%0d idx=%0d, want 1/5/1", got, gap, o_frame_index);
    end
    repeat (9) @(negedge clk);
    pulse_restart();
    n_checks++;
    if (o_load_stb !== 1'b1 || o_frame_index !== 8'd0) begin
      n_errors++;
      $display("FAIL restart_tick: got stb=%b idx=%0d, want 1/0", o_load_stb, o_frame_index);
    end
    @(negedge clk);
    n_checks++;
    if (o_load_stb !== 1'b0) begin
      n_errors++;
      $display("FAIL restart_single: got stb=%b, want 0", o_load_stb);
    end
    wait_stb(40, gap, got);
    n_checks++;
    if (!got || gap != 9 || o_frame_index !== 8'd1) begin
      n_errors++;
      $display("FAIL restart_next: got strobe=%b gap=%0d idx=%0d, want 1/9/1", got, gap, o_frame_index);
    end
  endtask

  task automatic test_count_change();
    int gap;
    bit got;
    i_mode = 2'd0;
    i_frame_count = 8'd8;
    pulse_restart();
    repeat (5) wait_stb(40, gap, got);
    n_checks++;
    if (o_frame_index !== 8'd5 || o_load_addr !== 24'h80_A000) begin
      n_errors++;
      $display("FAIL count8_idx5: got idx=%0d addr=%h, want 5/80a000", o_frame_index, o_load_addr);
    end
    i_frame_count = 8'd3;
    wait_stb(40, gap, got);
    n_checks++;
    if (!got || gap != 10 || o_frame_index !== 8'd0) begin
      n_errors++;
      $display("FAIL count_lowered: got strobe=%b gap=%0d idx=%0d, want 1/10/0", got, gap, o_frame_index);
    end
    i_frame_count = 8'd0;
    for (int k = 0; k < 2; k++) begin
      wait_stb(40, gap, got);
      n_checks++;
      if (!got || gap != 10 || o_frame_index !== 8'd0) begin
        n_errors++;
        $display("FAIL count_zero%0d: got strobe=%b gap=%0d idx=%0d, want 1/10/0", k, got, gap, o_frame_index);
      end
    end
  endtask

  task automatic test_reset_mid();
    int gap;
    bit got;
    int stray;
    i_mode = 2'd0;
    i_frame_count = 8'd3;
    pulse_restart();
    wait_stb(40, gap, got);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    stray = 0;
    repeat (3) begin
      @(negedge clk);
      if (o_load_stb) stray++;
    end
    n_checks++;
    if (stray != 0 || o_frame_index !== 8'd0 || o_load_addr !== 24'h80_0000 || o_done !== 1'b0 || o_dropped !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid: got strobes=%0d idx=%0d addr=%h done=%b drop=%b, want 0/0/800000/0/0",
               stray, o_frame_index, o_load_addr, o_done, o_dropped);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_load_stb !== 1'b1 || o_frame_index !== 8'd0) begin
      n_errors++;
      $display("FAIL reset_mid_prime: got stb=%b idx=%0d, want 1/0", o_load_stb, o_frame_index);
    end
    wait_stb(40, gap, got);
    n_checks++;
    if (!got || gap != 10 || o_frame_index !== 8'd1) begin
      n_errors++;
      $display("FAIL reset_mid_next: got strobe=%b gap=%0d idx=%0d, want 1/10/1", got, gap, o_frame_index);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_pingpong();
    test_oneshot();
    test_busy();
    test_pause();
    test_count_change();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
